// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline stage with one-entry skid buffer; ID_EX_PERF_EN adds stall/bubble counters.
module id_ex_pipe #(
  parameter int XLEN = 32,
  parameter int ALUCTL_W = 4,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     predictpc,
  input  logic [31:0]         instr,
  input  logic                regwrite,
  input  logic                memread,
  input  logic                memwrite,
  input  logic                alusrc,
  input  logic                regsrc,
  input  logic                pc_rs1_sel,
  input  logic [ALUCTL_W-1:0] alucontrol,
  input  logic [2:0]          immsel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pcE,
  output logic [XLEN-1:0]     predictpcE,
  output logic [XLEN-1:0]     imm,
  output logic                regwriteE,
  output logic                memreadE,
  output logic                memwriteE,
  output logic                alusrcE,
  output logic                regsrcE,
  output logic                pc_rs1_selE,
  output logic                branch,
  output logic [ALUCTL_W-1:0] alucontrolE,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rdE,
  output logic [4:0]          opcode,
  output logic [2:0]          f3,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     predictpc;
    logic [XLEN-1:0]     imm;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                alusrc;
    logic                regsrc;
    logic                pc_rs1_sel;
    logic                branch;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [4:0]          opcode;
    logic [2:0]          f3;
  } bundle_t;
  bundle_t in_b, main_q, skid_q;
  logic main_valid, skid_valid, accept, branch_d;
  logic [XLEN-1:0] imm_d;
  logic unused;
  assign unused = ^instr[1:0];
  // B and J immediates keep the half-offset encoding; EX applies the implicit LSB.
  assign imm_d = immsel == 3'd0 ? XLEN'($signed(instr[31:20])) :
                 immsel == 3'd1 ? XLEN'(instr[24:20]) :
                 immsel == 3'd2 ? XLEN'($signed({instr[31:25], instr[11:7]})) :
                 immsel == 3'd3 ? XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8]})) :
                 immsel == 3'd4 ? XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21]})) :
                 immsel == 3'd5 ? XLEN'($signed({instr[31:12], 12'b0})) : '0;
  assign branch_d = instr[6:2] == 5'b11000 || instr[6:2] == 5'b11011 || instr[6:2] == 5'b11001;
  assign in_b = {pc, predictpc, imm_d, regwrite, memread, memwrite, alusrc, regsrc, pc_rs1_sel,
                 branch_d, alucontrol, instr[19:15], instr[24:20], instr[11:7], instr[6:2], instr[14:12]};
  assign in_ready = ~skid_valid;
  assign accept = in_valid & in_ready & ~flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_ready) begin
      main_valid <= skid_valid | accept;
      skid_valid <= 1'b0;
      if (skid_valid) main_q <= skid_q;
      else if (accept) main_q <= in_b;
    end else if (accept) begin
      skid_q <= in_b;
      skid_valid <= 1'b1;
    end
  end
  assign out_valid = main_valid;
  assign {pcE, predictpcE, imm} = {main_q.pc, main_q.predictpc, main_q.imm};
  assign {alusrcE, regsrcE, pc_rs1_selE, alucontrolE} = {main_q.alusrc, main_q.regsrc, main_q.pc_rs1_sel, main_q.alucontrol};
  assign {rs1, rs2, rdE, opcode, f3} = {main_q.rs1, main_q.rs2, main_q.rd, main_q.opcode, main_q.f3};
  assign regwriteE = main_q.regwrite & main_valid;
  assign memreadE = main_q.memread & main_valid;
  assign memwriteE = main_q.memwrite & main_valid;
  assign branch = main_q.branch & main_valid;
`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;
  logic [CNT_W:0] bubble_sum;
  assign bubble_sum = {1'b0, bubble_q} + (CNT_W+1)'(main_valid) + (CNT_W+1)'(skid_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      bubble_q <= '0;
    end else begin
      if (main_valid && !out_ready && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (flush) bubble_q <= bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
    end
  end
  assign stall_cnt = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt = '0;
  assign bubble_cnt = '0;
`endif
endmodule
